// File: rtl/elgamal_ephemeral_key_sampler.sv
// Draws the ElGamal ephemeral exponent k uniformly from [2, p-2] by masking LFSR output
// to the bit length of p and rejecting out-of-range candidates, with a bounded retry count.
module elgamal_ephemeral_key_sampler #(
    parameter int WIDTH     = 64,
    parameter int MAX_TRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WIDTH-1:0]               p,
    output logic                           lfsr_en,
    input  logic                           rnd_valid,
    input  logic [WIDTH-1:0]               rnd,
    output logic [WIDTH-1:0]               k,
    output logic                           k_valid,
    input  logic                           k_ready,
    output logic                           busy,
    output logic                           error,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    logic [2:0]       state;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] k_q;
    logic [TW-1:0]    tries_q;
    logic [TW-1:0]    tries_inc;
    logic             in_range;
    logic             range_empty;

    // Smear the MSB of v downwards so the mask covers exactly the bit length of v.
    function automatic logic [WIDTH-1:0] msb_mask(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    assign range_empty = (p < WIDTH'(4));
    assign in_range    = (cand_q >= WIDTH'(2)) && (cand_q <= p_q - WIDTH'(2));
    assign tries_inc   = tries_q + TW'(1);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    // NOTE: the datapath registers are reset too because k must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            p_q     <= '0;
            mask_q  <= '0;
            cand_q  <= '0;
            k_q     <= '0;
            tries_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p_q     <= p;
                        mask_q  <= msb_mask(p);
                        tries_q <= '0;
                        state   <= range_empty ? S_FAIL : S_REQ;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (rnd_valid) begin
                        cand_q <= rnd & mask_q;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (in_range) begin
                        k_q   <= cand_q;
                        state <= S_HOLD;
                    end else begin
                        tries_q <= tries_inc;
                        state   <= (tries_inc == TRY_LIMIT) ? S_FAIL : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (k_ready) state <= S_IDLE;
                end
                S_FAIL:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control outputs decode straight from the state register, so they are glitch-free
    // and return to their reset values the moment rst falls.
    assign lfsr_en = (state == S_REQ);
    assign k_valid = (state == S_HOLD);
    assign busy    = (state != S_IDLE);
    assign error   = (state == S_FAIL);
    assign k       = k_q;
    assign tries   = tries_q;

endmodule

// File: tb/tb_elgamal_ephemeral_key_sampler.sv
// Directed bench for elgamal_ephemeral_key_sampler: a request-level model predicts every
// output cycle by cycle from draw counts, checked by a single compare process.
module tb_elgamal_ephemeral_key_sampler;

    localparam int WIDTH     = 64;
    localparam int MAX_TRIES = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] p = '0;
    logic             lfsr_en;
    logic             rnd_valid;
    logic [WIDTH-1:0] rnd = '0;
    logic [WIDTH-1:0] k;
    logic             k_valid;
    logic             k_ready = 1'b0;
    logic             busy;
    logic             error;
    logic [4:0]       tries;

    elgamal_ephemeral_key_sampler #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .lfsr_en(lfsr_en),
        .rnd_valid(rnd_valid), .rnd(rnd), .k(k), .k_valid(k_valid), .k_ready(k_ready),
        .busy(busy), .error(error), .tries(tries)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // LFSR stand-in: each step request presents the next queued value (or a default).
    logic [63:0] rnd_q[$];
    logic [63:0] default_rnd = '1;
    bit          rv_en = 1'b1;
    int          pulses = 0;
    assign rnd_valid = rv_en;

    always @(negedge clk) begin
        if (lfsr_en) begin
            pulses++;
            rnd = (rnd_q.size() > 0) ? rnd_q.pop_front() : default_rnd;
        end
    end

    // Expected outputs, updated by the request model just after every rising edge.
    bit          cmp_en = 1'b0;
    bit          exp_busy = 1'b0, exp_en = 1'b0, exp_err = 1'b0, exp_kv = 1'b0;
    logic [63:0] exp_k = '0;
    int          exp_tries = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",    64'(busy),    64'(exp_busy));
            check("lfsr_en", 64'(lfsr_en), 64'(exp_en));
            check("error",   64'(error),   64'(exp_err));
            check("k_valid", 64'(k_valid), 64'(exp_kv));
            check("k",       k,            exp_k);
            check("tries",   64'(tries),   64'(exp_tries));
        end
    end

    logic [63:0] old_k = '0;
    int          old_tries = 0;
    logic [63:0] mdl_k;
    int          mdl_rej;
    int          mdl_n;
    bit          mdl_ok;

    function automatic logic [63:0] mask_model(input logic [63:0] v);
        logic [63:0] m;
        m = '0;
        while (m < v) m = m * 2 + 1;
        return m;
    endfunction

    task automatic do_idle(input int cycles);
        exp_busy = 0; exp_en = 0; exp_err = 0; exp_kv = 0;
        exp_k = old_k; exp_tries = old_tries;
        cmp_en = 1;
        repeat (cycles) @(posedge clk);
        #1 cmp_en = 0;
    endtask

    // One request: predict the draw sequence, then walk the timeline. Draw i asserts
    // lfsr_en at cycle 1+3i; k_valid (or error) appears at cycle 3n+1 after n draws.
    task automatic do_request(input logic [63:0] pv, input int hold);
        logic [63:0] src[$];
        logic [63:0] m, cand, newk;
        int n, n_rej, t0, last;
        bit ok;
        src = rnd_q;
        ok = 0; n = 0; n_rej = 0; newk = old_k;
        m = mask_model(pv);
        if (pv >= 64'd4) begin
            while (!ok && n_rej < MAX_TRIES) begin
                cand = ((src.size() > 0) ? src.pop_front() : default_rnd) & m;
                n++;
                if (cand >= 64'd2 && cand <= pv - 64'd2) begin
                    ok = 1;
                    newk = cand;
                end else begin
                    n_rej++;
                end
            end
        end
        mdl_k = newk; mdl_rej = n_rej; mdl_n = n; mdl_ok = ok;
        t0 = 3 * n + 1;
        last = ok ? t0 + hold : t0;

        @(negedge clk);
        start = 1; p = pv; pulses = 0; cmp_en = 1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= last + 1; c++) begin
            exp_busy  = (c <= last);
            exp_en    = ((c - 1) % 3 == 0) && ((c - 1) / 3 < n);
            exp_err   = !ok && (c == t0);
            exp_tries = ((c - 1) / 3 < n_rej) ? (c - 1) / 3 : n_rej;
            exp_kv    = ok && (c >= t0) && (c <= last);
            exp_k     = (ok && c >= t0) ? newk : old_k;
            k_ready   = ok && (c == t0 + hold);
            // A start while holding k must be ignored; p=7 would be accepted if it leaked.
            start     = ok && (hold > 0) && (c == t0);
            p         = start ? 64'd7 : '1;
            @(posedge clk);
            #1;
        end
        start = 0; k_ready = 0; cmp_en = 0;
        check("lfsr_pulses", 64'(pulses), 64'(n));
        old_k = newk;
        old_tries = n_rej;
        rnd_q.delete();
    endtask

    initial begin
        #12 rst = 1'b1;
        do_idle(3);

        // Best case: first draw accepted.
        rnd_q.push_back(64'hABCD_0000_0000_0005);
        do_request(64'd23, 0);
        check("model_k_first", mdl_k, 64'd5);
        check("model_n_first", 64'(mdl_n), 64'd1);
        check("dut_k_first", k, 64'd5);

        // Three rejections (31, 22, 1) before accepting 3.
        rnd_q.push_back(64'h1234_5678_9ABC_DEFF);
        rnd_q.push_back(64'h0000_0000_0000_0036);
        rnd_q.push_back(64'hFFFF_0000_0000_0021);
        rnd_q.push_back(64'h8000_0000_0000_0003);
        do_request(64'd23, 2);
        check("model_k_rej", mdl_k, 64'd3);
        check("model_tries_rej", 64'(mdl_rej), 64'd3);
        check("dut_tries_rej", 64'(tries), 64'd3);

        // Empty ranges.
        do_request(64'd3, 0);
        check("model_empty_ok", 64'(mdl_ok), 64'd0);
        do_request(64'd0, 0);

        // Exhaust the retry budget.
        do_request(64'd23, 0);
        check("model_fail_rej", 64'(mdl_rej), 64'd16);
        check("dut_tries_fail", 64'(tries), 64'd16);
        check("dut_k_after_fail", k, 64'd3);

        // Backpressure: k held for five cycles with a start attempt in between.
        rnd_q.push_back(64'h0000_0000_0000_0007);
        do_request(64'd23, 5);

        // Narrow ranges at the small end.
        rnd_q.push_back(64'd0); rnd_q.push_back(64'd1);
        rnd_q.push_back(64'd4); rnd_q.push_back(64'd2);
        do_request(64'd5, 1);
        check("model_k_p5", mdl_k, 64'd2);
        rnd_q.push_back(64'd3); rnd_q.push_back(64'hF2);
        do_request(64'd4, 0);
        check("model_k_p4", mdl_k, 64'd2);

        // Full-width prime: p-1 rejected, p-2 accepted.
        rnd_q.push_back(64'hFFFF_FFFF_FFFF_FFC4);
        rnd_q.push_back(64'hFFFF_FFFF_FFFF_FFC3);
        do_request(64'hFFFF_FFFF_FFFF_FFC5, 0);
        check("dut_k_wide", k, 64'hFFFF_FFFF_FFFF_FFC3);

        // Reset while waiting on the LFSR, then a fresh request.
        rv_en = 0;
        rnd_q.push_back(64'd5);
        @(negedge clk);
        start = 1; p = 64'd23;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_lfsr_en", 64'(lfsr_en), 64'd0);
        check("rst_k_valid", 64'(k_valid), 64'd0);
        check("rst_error",   64'(error),   64'd0);
        check("rst_k",       k,            64'd0);
        check("rst_tries",   64'(tries),   64'd0);
        @(negedge clk);
        rst = 1'b1; rv_en = 1;
        rnd_q.delete();
        old_k = '0; old_tries = 0;
        do_idle(2);
        rnd_q.push_back(64'h0000_0000_0000_0009);
        do_request(64'd23, 0);
        check("dut_k_after_rst", k, 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
